cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Instruction sequencer for the 4-bit `cpu` datapath. Holds a small program memory, loaded through a valid/ready handshake, and owns the program counter. It presents one instruction per clock on `opecode`/`imm` with an execute enable, and resolves the `JMP`/`JNC` branches locally using the datapath's carry flag. Run, pause, single-step and abort controls let a bench or host sequence the datapath instead of driving `opecode` directly.

## Interface
- `OP_W`, 4: opcode width; must match the datapath.
- `IMM_W`, 4: immediate width; also the PC width. Program depth is 2**IMM_W = 16.
- `clk`  in  1  clock.
- `n_rst`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  program-write request.
- `load_ready`  out  1  program write accepted this cycle when high together with `load_valid`.
- `load_addr`  in  IMM_W  program word address.
- `load_data`  in  OP_W+IMM_W  instruction word: {opcode[7:4], imm[3:0]}.
- `run`  in  1  start request, or resume request.
- `step`  in  1  execute exactly one instruction while paused.
- `halt_req`  in  1  pause request.
- `abort`  in  1  return to IDLE with PC = 0.
- `carry`  in  1  registered carry flag from the datapath.
- `opecode`  out  OP_W  current instruction opcode.
- `imm`  out  IMM_W  current instruction immediate.
- `exec_en`  out  1  datapath commits the current instruction at this clock edge.
- `pc`  out  IMM_W  program counter.
- `halted`  out  1  stopped on a self-loop (see Configuration).

## Operation
- States: IDLE, RUN, PAUSE.
- Outputs `opecode`/`imm` are always the memory word at `mem[pc]`.
- Control priority within one cycle: `abort` > `halt_req` > `run` > `step`.
- **IDLE**
  - `load_ready` = 1 and `exec_en` = 0.
  - A load handshake writes `mem[load_addr] <= load_data` at the clock edge.
  - `run` moves to RUN with PC = 0.
- **RUN**
  - `exec_en` = 1 every cycle; `load_ready` = 0.
  - `halt_req` moves to PAUSE. The instruction presented in that same cycle does not commit, so `exec_en` drops in the same cycle as `halt_req` (combinational gating).
- **PAUSE**
  - `exec_en` = 0 except during a `step` cycle.
  - `step` gives `exec_en` = 1 for that cycle only and advances the PC once.
  - `run` returns to RUN.
- **Abort:** `abort` in any state moves to IDLE with PC = 0 and clears `halted`. `exec_en` = 0 in the abort cycle.
- **PC update** on every edge where `exec_en` = 1:
  - `JMP` (4'b1111): `pc <= imm`.
  - `JNC` (4'b1110): `pc <= imm` if `carry` = 0, otherwise `pc + 1`.
  - All other opcodes: `pc + 1`. Wraps modulo 16 (15 → 0) with no flag.
- The datapath treats `JMP`/`JNC` as register no-ops; the sequencer still asserts `exec_en` for them.
- Program memory is not reset. Loads attempted outside IDLE are ignored and `load_ready` stays 0.

## Timing
- Reset values: state IDLE, `pc` = 0, `exec_en` = 0, `load_ready` = 1, `halted` = 0.
- Execution rate is one instruction per cycle with zero fetch latency: memory read is asynchronous, and `opecode`/`imm` change in the cycle after the PC edge.
- Load-to-run: a word written at edge N is visible on `opecode` from edge N if `pc` = `load_addr`.
- `carry` is sampled at the same edge as the branch decision. It is the flag produced by earlier instructions, not by the branch itself.
- Reset asserted mid-RUN forces IDLE immediately (asynchronous); memory contents are preserved.

## Configuration
- Macro: `CPU_SEQ_SELFLOOP_HALT_EN`.
- **Defined:** a committed `JMP` with `imm == pc`, or a taken `JNC` with `imm == pc`, moves to PAUSE and sets `halted` = 1. `halted` clears on `run`, `step` or `abort`.
- **Undefined:** self-loops execute forever in RUN; `halted` is tied to 0.

## Structure
- Package `cpu_pkg`:
  - opcode enum: `ADD_A`=0, `MOV_AB`=1, `IN_A`=2, `MOV_A`=3, `MOV_BA`=4, `ADD_B`=5, `IN_B`=6, `MOV_B`=7, `OUT_B`=9, `OUT_IM`=11, `JNC`=14, `JMP`=15.
  - `seq_state_t` {IDLE, RUN, PAUSE}.
  - `OP_W`, `IMM_W`.
- Sub-module `cpu_prog_mem`: 16×8 register array, one synchronous write port, one asynchronous read port, no reset.
- The FSM, PC and branch resolution live in `cpu_sequencer`.

## Test plan
- **Reset / load:** after reset, `pc` = 0, `load_ready` = 1, `exec_en` = 0. Load `mem[0]` = 8'h35 → `opecode` = 3, `imm` = 5.
- **Straight-line run:** program {0x35 `MOV A,5`, 0x40 `MOV B,A`, 0x90 `OUT B`, 0xF3 `JMP 3`}, then `run`.
  - `exec_en` is high for four consecutive cycles.
  - `pc` sequence is 0, 1, 2, 3.
  - The datapath `led` = 5.
  - With the macro defined: `halted` = 1 and state PAUSE after the `JMP 3` commits.
- **JNC:** `mem[0]` = 8'hE4.
  - With `carry` = 0: `pc` goes 0 → 4.
  - With `carry` = 1: `pc` goes 0 → 1.
- **Pause / step:** `halt_req` at `pc` = 2 → `exec_en` = 0 that cycle and `pc` holds at 2. `step` → `pc` = 3 after exactly one cycle with `exec_en` = 1.
- **Wrap:** sixteen `ADD A,0` (0x00) words run from `pc` = 15 → `pc` = 0 on the next edge.
- **Priority / abort:**
  - `abort` + `run` in the same RUN cycle → IDLE, `pc` = 0, `exec_en` = 0.
  - A load attempted during RUN → `load_ready` = 0 and memory unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and widths for the 4-bit cpu datapath and its instruction sequencer.
package cpu_pkg;

  localparam int OP_W       = 4;
  localparam int IMM_W      = 4;
  localparam int PROG_DEPTH = 2 ** IMM_W;

  typedef enum logic [3:0] {
    ADD_A  = 4'd0,
    MOV_AB = 4'd1,
    IN_A   = 4'd2,
    MOV_A  = 4'd3,
    MOV_BA = 4'd4,
    ADD_B  = 4'd5,
    IN_B   = 4'd6,
    MOV_B  = 4'd7,
    OUT_B  = 4'd9,
    OUT_IM = 4'd11,
    JNC    = 4'd14,
    JMP    = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } seq_state_t;

endpackage

// File: rtl/cpu_prog_mem.sv
// Program store: one synchronous write port and one asynchronous read port, no reset.
module cpu_prog_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: program memory, PC, run/pause/step/abort control, local JMP/JNC.
// Optional macro CPU_SEQ_SELFLOOP_HALT_EN pauses and flags halted on a committed self-loop branch.
module cpu_sequencer #(
  parameter int OP_W  = 4,
  parameter int IMM_W = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [IMM_W-1:0]      load_addr,
  input  logic [OP_W+IMM_W-1:0] load_data,
  input  logic                  run,
  input  logic                  step,
  input  logic                  halt_req,
  input  logic                  abort,
  input  logic                  carry,
  output logic [OP_W-1:0]       opecode,
  output logic [IMM_W-1:0]      imm,
  output logic                  exec_en,
  output logic [IMM_W-1:0]      pc,
  output logic                  halted
);
  import cpu_pkg::*;

  localparam int WORD_W = OP_W + IMM_W;

  seq_state_t         state_q, state_d;
  logic [IMM_W-1:0]   pc_q, pc_d;
  logic               halted_q, halted_d;
  logic [WORD_W-1:0]  rd_word;
  logic               mem_we;
  logic               is_jmp, is_jnc, branch_taken;
  logic [IMM_W-1:0]   pc_exec;

  assign load_ready = (state_q == IDLE);
  assign mem_we     = load_valid && load_ready;

  cpu_prog_mem #(
    .DATA_W (WORD_W),
    .ADDR_W (IMM_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (rd_word)
  );

  assign opecode = rd_word[WORD_W-1:IMM_W];
  assign imm     = rd_word[IMM_W-1:0];
  assign pc      = pc_q;
  assign halted  = halted_q;

  assign is_jmp       = (opecode == OP_W'(JMP));
  assign is_jnc       = (opecode == OP_W'(JNC));
  assign branch_taken = is_jmp || (is_jnc && !carry);
  assign pc_exec      = branch_taken ? imm : pc_q + 1'b1;

  // Commit is gated combinationally so a same-cycle abort or halt_req suppresses it.
  always_comb begin
    exec_en = 1'b0;
    if (!abort && !halt_req) begin
      if (state_q == RUN) begin
        exec_en = 1'b1;
      end else if (state_q == PAUSE && !run && step) begin
        exec_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (abort) begin
      state_d  = IDLE;
      pc_d     = '0;
      halted_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt_req && run) begin
            state_d = RUN;
            pc_d    = '0;
          end
        end
        RUN: begin
          if (halt_req) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (!halt_req && run) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
      if (exec_en) begin
        pc_d = pc_exec;
      end
`ifdef CPU_SEQ_SELFLOOP_HALT_EN
      if (run || step) begin
        halted_d = 1'b0;
      end
      // A taken branch onto itself can never make progress, so park in PAUSE.
      if (exec_en && branch_taken && (imm == pc_q)) begin
        state_d  = PAUSE;
        halted_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues expected commits, a monitor checks every exec_en cycle.
module tb_cpu_sequencer;

  logic       clk;
  logic       n_rst;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       run, step, halt_req, abort, carry;
  logic [3:0] opecode, imm, pc;
  logic       exec_en, halted;

  typedef struct {
    logic [3:0] pc;
    logic [7:0] word;
  } commit_t;

  commit_t exp_q[$];
  int checks = 0;
  int errors = 0;

  cpu_sequencer #(.OP_W(4), .IMM_W(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .run        (run),
    .step       (step),
    .halt_req   (halt_req),
    .abort      (abort),
    .carry      (carry),
    .opecode    (opecode),
    .imm        (imm),
    .exec_en    (exec_en),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every committed instruction must match the head of the expectation queue.
  always @(negedge clk) begin
    if (n_rst && exec_en) begin
      commit_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit: unexpected exec_en at pc %0h word %02h, none required", pc, {opecode, imm});
      end else begin
        e = exp_q.pop_front();
        if (pc !== e.pc || {opecode, imm} !== e.word) begin
          errors++;
          $display("FAIL commit: got pc %0h word %02h, required pc %0h word %02h",
                   pc, {opecode, imm}, e.pc, e.word);
        end else begin
          $display("commit pc %0h word %02h", pc, {opecode, imm});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  task automatic push(input logic [3:0] p, input logic [7:0] w);
    commit_t e;
    e.pc   = p;
    e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    #1;
    check("load_ready_idle", {7'd0, load_ready}, 8'd1);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    #1;
    check("exec_en_abort", {7'd0, exec_en}, 8'd0);
    tick();
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    run = 1'b0; step = 1'b0; halt_req = 1'b0; abort = 1'b0; carry = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    #1;
    check("reset_pc", {4'd0, pc}, 8'd0);
    check("reset_load_ready", {7'd0, load_ready}, 8'd1);
    check("reset_exec_en", {7'd0, exec_en}, 8'd0);
    check("reset_halted", {7'd0, halted}, 8'd0);

    // Load then read back through the async port
    load_word(4'd0, 8'h35);
    check("load_opecode", {4'd0, opecode}, 8'd3);
    check("load_imm", {4'd0, imm}, 8'd5);

    // Straight-line program ending in JMP 3
    load_word(4'd1, 8'h40);
    load_word(4'd2, 8'h90);
    load_word(4'd3, 8'hF3);
    push(4'd0, 8'h35); push(4'd1, 8'h40); push(4'd2, 8'h90); push(4'd3, 8'hF3);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("run_pc0", {4'd0, pc}, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("run_pc_seq", {4'd0, pc}, 8'(i));
    end
    tick();
    check("jmp3_pc", {4'd0, pc}, 8'd3);
`ifdef CPU_SEQ_SELFLOOP_HALT_EN
    check("selfloop_halted", {7'd0, halted}, 8'd1);
    check("selfloop_exec_en", {7'd0, exec_en}, 8'd0);
`else
    check("selfloop_halted", {7'd0, halted}, 8'd0);
    check("selfloop_exec_en", {7'd0, exec_en}, 8'd1);
    push(4'd3, 8'hF3);
    tick();
    check("selfloop_pc", {4'd0, pc}, 8'd3);
`endif
    do_abort();
    check("abort_pc", {4'd0, pc}, 8'd0);
    check("abort_halted", {7'd0, halted}, 8'd0);

    // JNC with carry clear (taken) and set (falls through)
    load_word(4'd0, 8'hE4);
    carry = 1'b0;
    push(4'd0, 8'hE4);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    check("jnc_taken_pc", {4'd0, pc}, 8'd4);
    do_abort();
    carry = 1'b1;
    push(4'd0, 8'hE4);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    check("jnc_fall_pc", {4'd0, pc}, 8'd1);
    do_abort();
    carry = 1'b0;

    // Pause and single step over ADD A,0 words
    for (int a = 0; a < 16; a++) load_word(4'(a), 8'h00);
    push(4'd0, 8'h00); push(4'd1, 8'h00);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    check("pause_pc_before", {4'd0, pc}, 8'd2);
    halt_req = 1'b1;
    #1;
    check("halt_exec_en", {7'd0, exec_en}, 8'd0);
    tick();
    halt_req = 1'b0;
    check("pause_pc_hold", {4'd0, pc}, 8'd2);
    tick();
    check("pause_pc_hold2", {4'd0, pc}, 8'd2);
    check("pause_exec_en", {7'd0, exec_en}, 8'd0);
    push(4'd2, 8'h00);
    step = 1'b1;
    #1;
    check("step_exec_en", {7'd0, exec_en}, 8'd1);
    tick();
    step = 1'b0;
    check("step_pc", {4'd0, pc}, 8'd3);
    tick();
    check("step_pc_hold", {4'd0, pc}, 8'd3);

    // Resume and wrap 15 -> 0
    run = 1'b1;
    #1;
    check("resume_exec_en", {7'd0, exec_en}, 8'd0);
    for (int p = 3; p < 16; p++) push(4'(p), 8'h00);
    push(4'd0, 8'h00);
    tick();
    run = 1'b0;
    repeat (13) tick();
    check("wrap_pc", {4'd0, pc}, 8'd0);
    tick();
    check("wrap_pc_next", {4'd0, pc}, 8'd1);

    // abort beats run in the same cycle
    run = 1'b1;
    do_abort();
    run = 1'b0;
    check("abort_run_pc", {4'd0, pc}, 8'd0);
    check("abort_run_ready", {7'd0, load_ready}, 8'd1);
    check("abort_run_exec", {7'd0, exec_en}, 8'd0);

    // Load attempted during RUN is refused
    push(4'd0, 8'h00);
    run = 1'b1;
    tick();
    run = 1'b0;
    load_valid = 1'b1; load_addr = 4'd5; load_data = 8'hAB;
    #1;
    check("run_load_ready", {7'd0, load_ready}, 8'd0);
    tick();
    load_valid = 1'b0;
    do_abort();
    for (int p = 0; p < 5; p++) push(4'(p), 8'h00);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (5) tick();
    halt_req = 1'b1;
    #1;
    check("mem_unchanged_pc", {4'd0, pc}, 8'd5);
    check("mem_unchanged_word", {opecode, imm}, 8'h00);
    tick();
    halt_req = 1'b0;
    do_abort();

    // Async reset mid-run preserves memory
    load_word(4'd0, 8'h35);
    push(4'd0, 8'h35);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    check("pre_reset_pc", {4'd0, pc}, 8'd1);
    n_rst = 1'b0;
    #1;
    check("async_reset_pc", {4'd0, pc}, 8'd0);
    check("async_reset_ready", {7'd0, load_ready}, 8'd1);
    check("async_reset_exec", {7'd0, exec_en}, 8'd0);
    tick();
    n_rst = 1'b1;
    #1;
    check("reset_keeps_mem", {opecode, imm}, 8'h35);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d commits outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
